// File: rtl/pc_ir_mdr_seq_if.sv
// Bus between the program loader / control unit and the PC/IR/MDR sequencer.
// Request-side signals flow master -> slave; register outputs and status flow back.
interface pc_ir_mdr_seq_if #(parameter int WIDTH = 32);
    logic             s;
    logic [WIDTH-1:0] dataddrIn;
    logic [WIDTH-1:0] dataIn;
    logic             run;
    logic             ld;
    logic             jmp;
    logic [WIDTH-1:0] pcOut;
    logic [WIDTH-1:0] IOut;
    logic [WIDTH-1:0] mOut;
    logic             E;
    logic             mV;
    logic             busy;
    logic             err;

    modport master (
        output s, dataddrIn, dataIn, run, ld, jmp,
        input  pcOut, IOut, mOut, E, mV, busy, err
    );

    modport slave (
        input  s, dataddrIn, dataIn, run, ld, jmp,
        output pcOut, IOut, mOut, E, mV, busy, err
    );
endinterface

// File: rtl/pc_ir_mdr_seq.sv
// PC/IR/MDR sequencer over a DEPTH-word synchronous memory: fetch, data load, PC jump.
// Fetch and load each take 2 cycles after leaving IDLE; ld/jmp outside IDLE are dropped, callers wait for busy=0.
module pc_ir_mdr_seq #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int RESET_PC = 0
) (
    input  logic clk,
    input  logic rst,
    pc_ir_mdr_seq_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, FETCH, WB_I, LOAD, WB_M} state_t;

    state_t           state, nextState;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdQ;
    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] mdr;
    logic [AW-1:0]    pc;
    logic [AW-1:0]    addrQ;
    logic [AW-1:0]    rdAddr;
    logic [AW-1:0]    reqAddr;
    logic             inRange;
    logic             ePulse;
    logic             mvPulse;
    logic             errQ;
    logic             pcJump;
    logic             pcInc;
    logic             irLoad;
    logic             mdrLoad;
    logic             addrLoad;
    logic             errSet;

    assign reqAddr = bus.dataddrIn[AW-1:0];
    assign inRange = (bus.dataddrIn >> AW) == '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        pcJump    = 1'b0;
        pcInc     = 1'b0;
        irLoad    = 1'b0;
        mdrLoad   = 1'b0;
        addrLoad  = 1'b0;
        rdAddr    = pc;
        errSet    = bus.s && !inRange;
        case (state)
            IDLE: begin
                // An out-of-range jmp/ld is consumed: flagged, not passed down to run.
                if (bus.jmp) begin
                    if (inRange) pcJump = 1'b1;
                    else         errSet = 1'b1;
                end else if (bus.ld) begin
                    if (inRange) begin
                        addrLoad  = 1'b1;
                        nextState = LOAD;
                    end else begin
                        errSet = 1'b1;
                    end
                end else if (bus.run) begin
                    nextState = FETCH;
                end
            end
            FETCH: begin
                rdAddr    = pc;
                nextState = WB_I;
            end
            WB_I: begin
                irLoad    = 1'b1;
                pcInc     = 1'b1;
                nextState = bus.run ? FETCH : IDLE;
            end
            LOAD: begin
                rdAddr    = addrQ;
                nextState = WB_M;
            end
            WB_M: begin
                mdrLoad   = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Read and write share one edge, so a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (bus.s && inRange) mem[reqAddr] <= bus.dataIn;
        rdQ <= mem[rdAddr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= AW'(RESET_PC);
            addrQ   <= '0;
            ir      <= '0;
            mdr     <= '0;
            ePulse  <= 1'b0;
            mvPulse <= 1'b0;
            errQ    <= 1'b0;
        end else begin
            if (pcJump)     pc <= reqAddr;
            else if (pcInc) pc <= pc + AW'(1);
            if (addrLoad)   addrQ <= reqAddr;
            if (irLoad)     ir <= rdQ;
            if (mdrLoad)    mdr <= rdQ;
            ePulse  <= irLoad;
            mvPulse <= mdrLoad;
            if (errSet)     errQ <= 1'b1;
        end
    end

    assign bus.pcOut = WIDTH'(pc);
    assign bus.IOut  = ir;
    assign bus.mOut  = mdr;
    assign bus.E     = ePulse;
    assign bus.mV    = mvPulse;
    assign bus.busy  = (state != IDLE);
    assign bus.err   = errQ;
endmodule

// File: tb/tb_pc_ir_mdr_seq.sv
// Directed bench for pc_ir_mdr_seq: scoreboarded fetch/load results plus a DEPTH=4, WIDTH=16 instance.
module tb_pc_ir_mdr_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_ir_mdr_seq_if #(.WIDTH(32)) ifA ();
    pc_ir_mdr_seq_if #(.WIDTH(16)) ifB ();

    pc_ir_mdr_seq #(.WIDTH(32), .DEPTH(16), .RESET_PC(0)) dutA (.clk(clk), .rst(rst), .bus(ifA));
    pc_ir_mdr_seq #(.WIDTH(16), .DEPTH(4),  .RESET_PC(0)) dutB (.clk(clk), .rst(rst), .bus(ifB));

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
    } expI_t;

    int          passCnt  = 0;
    int          totalCnt = 0;
    expI_t       qI[$];
    logic [31:0] qM[$];
    logic [31:0] mdl[16];
    int          mpc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // All tasks start and end at a falling edge with requests deasserted.
    task automatic writeA(input int a, input logic [31:0] d);
        ifA.s = 1'b1; ifA.dataddrIn = a; ifA.dataIn = d;
        @(negedge clk);
        ifA.s = 1'b0;
        if (a < 16) mdl[a] = d;
    endtask

    task automatic jmpA(input int a);
        ifA.jmp = 1'b1; ifA.dataddrIn = a;
        @(negedge clk);
        ifA.jmp = 1'b0;
        if (a < 16) mpc = a;
    endtask

    task automatic fetchA(input int n);
        for (int i = 0; i < n; i++) begin
            qI.push_back('{mdl[mpc], (mpc + 1) % 16});
            mpc = (mpc + 1) % 16;
        end
        ifA.run = 1'b1;
        repeat (2 * n) @(negedge clk);
        ifA.run = 1'b0;
    endtask

    task automatic ldA(input int a);
        qM.push_back(mdl[a]);
        ifA.ld = 1'b1; ifA.dataddrIn = a;
        @(negedge clk);
        ifA.ld = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((qI.size() != 0 || qM.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(tag, qI.size() + qM.size(), 0);
    endtask

    always @(negedge clk) begin
        expI_t       e;
        logic [31:0] m;
        if (rst) begin
            if (ifA.E) begin
                chk("E_expected", 32'(qI.size() != 0), 1);
                if (qI.size() != 0) begin
                    e = qI.pop_front();
                    chk("IOut", ifA.IOut, e.ir);
                    chk("pcOut_at_E", ifA.pcOut, e.pc);
                end
            end
            if (ifA.mV) begin
                chk("mV_expected", 32'(qM.size() != 0), 1);
                if (qM.size() != 0) begin
                    m = qM.pop_front();
                    chk("mOut", ifA.mOut, m);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifA.s = 0; ifA.run = 0; ifA.ld = 0; ifA.jmp = 0; ifA.dataddrIn = 0; ifA.dataIn = 0;
        ifB.s = 0; ifB.run = 0; ifB.ld = 0; ifB.jmp = 0; ifB.dataddrIn = 0; ifB.dataIn = 0;

        #12;
        chk("rst_pcOut", ifA.pcOut, 0);
        chk("rst_IOut",  ifA.IOut, 0);
        chk("rst_mOut",  ifA.mOut, 0);
        chk("rst_E",     32'(ifA.E), 0);
        chk("rst_mV",    32'(ifA.mV), 0);
        chk("rst_err",   32'(ifA.err), 0);
        chk("rst_busy",  32'(ifA.busy), 0);
        ifA.run = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_hold_busy", 32'(ifA.busy), 0);
        ifA.run = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        writeA(0, 69);
        writeA(1, 70);

        // reset while a fetch is in flight
        ifA.run = 1'b1;
        @(negedge clk);
        chk("midfetch_busy", 32'(ifA.busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_pcOut", ifA.pcOut, 0);
        chk("midrst_IOut",  ifA.IOut, 0);
        chk("midrst_E",     32'(ifA.E), 0);
        chk("midrst_busy",  32'(ifA.busy), 0);
        ifA.run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("postrst_IOut", ifA.IOut, 0);
        chk("postrst_pcOut", ifA.pcOut, 0);
        mpc = 0;

        fetchA(2);
        drain("drain_fetch2");
        chk("fetch2_pcOut", ifA.pcOut, 2);

        writeA(15, 32'hA5);
        jmpA(15);
        chk("jmp15_pcOut", ifA.pcOut, 15);
        fetchA(1);
        drain("drain_wrap");
        chk("wrap_pcOut", ifA.pcOut, 0);

        writeA(10, 69);
        ldA(10);
        chk("load_busy", 32'(ifA.busy), 1);
        drain("drain_load");

        // write 99 to the address being read in the LOAD cycle
        qM.push_back(69);
        ifA.ld = 1'b1; ifA.dataddrIn = 10;
        @(negedge clk);
        ifA.ld = 1'b0; ifA.s = 1'b1; ifA.dataIn = 99;
        @(negedge clk);
        ifA.s = 1'b0;
        mdl[10] = 99;
        drain("drain_rdw");
        ldA(10);
        drain("drain_load99");

        ifA.jmp = 1'b1; ifA.ld = 1'b1; ifA.dataddrIn = 5;
        @(negedge clk);
        ifA.jmp = 1'b0; ifA.ld = 1'b0;
        mpc = 5;
        chk("prio_busy", 32'(ifA.busy), 0);
        chk("prio_pcOut", ifA.pcOut, 5);
        repeat (4) @(negedge clk);
        chk("prio_mOut", ifA.mOut, 99);

        writeA(4, 32'h44);
        chk("err_before", 32'(ifA.err), 0);
        writeA(20, 32'h1234);
        chk("err_set", 32'(ifA.err), 1);
        jmpA(20);
        chk("oor_jmp_pcOut", ifA.pcOut, 5);
        ifA.ld = 1'b1; ifA.dataddrIn = 20;
        @(negedge clk);
        ifA.ld = 1'b0;
        chk("oor_ld_busy", 32'(ifA.busy), 0);
        jmpA(4);
        fetchA(1);
        drain("drain_oor_mem");
        chk("err_sticky", 32'(ifA.err), 1);
        rst = 1'b0;
        #1;
        chk("err_cleared", 32'(ifA.err), 0);
        @(negedge clk);
        rst = 1'b1;
        mpc = 0;

        // narrow, shallow instance: wrap 3 -> 0 and zero extension
        ifB.s = 1'b1; ifB.dataddrIn = 3; ifB.dataIn = 16'hBEEF;
        @(negedge clk);
        ifB.s = 1'b0; ifB.jmp = 1'b1;
        @(negedge clk);
        ifB.jmp = 1'b0;
        chk("B_jmp_pcOut", 32'(ifB.pcOut), 3);
        ifB.run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("B_E_early", 32'(ifB.E), 0);
        ifB.run = 1'b0;
        @(negedge clk);
        chk("B_E", 32'(ifB.E), 1);
        chk("B_IOut", 32'(ifB.IOut), 32'hBEEF);
        chk("B_wrap_pcOut", 32'(ifB.pcOut), 0);
        @(negedge clk);
        chk("B_E_pulse", 32'(ifB.E), 0);
        ifB.jmp = 1'b1; ifB.dataddrIn = 4;
        @(negedge clk);
        ifB.jmp = 1'b0;
        chk("B_oor_err", 32'(ifB.err), 1);
        chk("B_oor_pcOut", 32'(ifB.pcOut), 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/pc_ir_mdr_seq.md
Name: pc_ir_mdr_seq

Overview:
- Parametrised successor to the fixed 32-bit PC/IR/MDR register block.
- Contains a DEPTH-word synchronous instruction/data memory, an external write port, and a small FSM.
- The FSM sequences instruction fetch (PC → IR, PC auto-increment with wrap), data load (address → MDR) and PC jumps.
- Sits between the program loader/testbench and the control unit of the multi-cycle CPU.

Parameters:
- WIDTH, 32, data/instruction/PC width in bits.
- DEPTH, 16, memory depth in words; power of two, ≥2; AW = log2(DEPTH) is a localparam.
- RESET_PC, 0, PC value loaded on reset; must be < DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- s  in  1  memory write strobe.
- dataddrIn  in  WIDTH  address for writes, loads and jumps.
- dataIn  in  WIDTH  write data.
- run  in  1  fetch request; level-sensitive.
- ld  in  1  data load request (one-cycle pulse sampled in IDLE).
- jmp  in  1  PC load request (sampled in IDLE).
- pcOut  out  WIDTH  program counter, zero-extended from AW bits.
- IOut  out  WIDTH  instruction register.
- mOut  out  WIDTH  memory data register.
- E  out  1  one-cycle pulse: IOut just updated.
- mV  out  1  one-cycle pulse: mOut just updated.
- busy  out  1  FSM not in IDLE.
- err  out  1  sticky out-of-range flag.

Behaviour:
- Reset (rst=0, asynchronous): pcOut=RESET_PC, IOut=0, mOut=0, E=0, mV=0, err=0, state=IDLE. Memory contents are not cleared. All registers hold at reset values while rst=0.
- Memory read: synchronous. rd_q <= mem[rd_addr] on each edge, 1-cycle latency.
- Read-during-write to the same address returns the old data.
- Writes: on any edge with s=1 and dataddrIn < DEPTH, mem[dataddrIn[AW-1:0]] <= dataIn. Writes are accepted in every FSM state.
- Out of range: any s write, ld or jmp with dataddrIn >= DEPTH is ignored (no write, no load, no PC change) and sets err=1. err clears only on reset.
- FSM states: IDLE, FETCH, WB_I, LOAD, WB_M.
- IDLE priority: jmp > ld > run.
  - jmp: pcOut <= dataddrIn[AW-1:0]; remain in IDLE.
  - ld: latch addr_q <= dataddrIn; go to LOAD.
  - run: go to FETCH.
- FETCH: rd_addr = pcOut; go to WB_I.
- WB_I:
  - IOut <= rd_q and E <= 1, registered and coincident with the new IOut.
  - pcOut <= pcOut+1, wrapping DEPTH-1 → 0.
  - If run=1, go to FETCH; else go to IDLE.
- LOAD: rd_addr = addr_q; go to WB_M.
- WB_M: mOut <= rd_q, mV <= 1; go to IDLE.
- Timing: fetch latency is 2 cycles from leaving IDLE. Sustained throughput is one instruction per 2 cycles while run=1. Load latency is 2 cycles.
- Ignored requests: ld and jmp outside IDLE are ignored and not queued. A caller holds them until busy=0.
- E and mV are 0 in every cycle not described above.
- Reset mid-operation: the FSM returns to IDLE, an in-flight fetch/load is discarded, and no E or mV pulse is produced.
- pcOut upper WIDTH-AW bits are always 0.

Test Plan:
- Reset mid-fetch: assert run, drop rst during FETCH → same cycle pcOut=0, IOut=0, E=0, state IDLE; release rst → nothing updates until run is seen.
- Write then fetch: s=1 writing mem[0]=69, mem[1]=70; run=1 for 4 cycles → E pulses twice 2 cycles apart, IOut=69 then 70, pcOut=1 then 2.
- PC wrap: jmp with dataddrIn=15 (DEPTH=16), mem[15]=0xA5; fetch once → IOut=0xA5, pcOut=0.
- Data load and read-during-write: write mem[10]=69; pulse ld with dataddrIn=10 → 2 cycles later mOut=69, mV pulse. Repeat with s writing 99 to address 10 in the LOAD cycle → mOut=69.
- Priority and out of range: jmp and ld together in IDLE → PC loaded, no load. s=1 with dataddrIn=20 → memory unchanged, err=1 until reset.
- Parameter sweep: WIDTH=16, DEPTH=4 → pcOut wraps 3 → 0, zero-extended; all above checks pass.
